if_id_inst_buffer: RTL and testbench
====================================

// Module: if_id_inst_buffer
// PURPOSE
//  Instruction buffer between the fetch stage and the decode/register-file stage of the 5-stage RV32I core.
//  Holds up to DEPTH fetched {pc, inst} pairs and presents the head entry to decode.
//  Slices rs1/rs2/rd addresses from the head instruction; these drive the general register file read ports.
//  Absorbs decode stalls via valid/ready, and discards all held entries on a branch/jump flush.
// PARAMETERS
//  DEPTH   2          entries; power of two, >= 2
//  XLEN    32         width of pc and inst; equals `RegBus width
//  NOP     32'h00000013  instruction presented when empty (addi x0,x0,0)
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     asynchronous reset, active-low
//  flush        in   1     EX redirect; drop all held and incoming entries this cycle
//  if_valid     in   1     fetch presents a valid {if_pc, if_inst}
//  if_ready     out  1     buffer accepts an entry this cycle
//  if_pc        in   XLEN  fetched pc
//  if_inst      in   XLEN  fetched instruction
//  id_valid     out  1     head entry valid for decode
//  id_ready     in   1     decode consumes the head entry this cycle
//  id_pc        out  XLEN  head pc
//  id_inst      out  XLEN  head instruction
//  id_rs1_addr  out  5     head inst[19:15]
//  id_rs2_addr  out  5     head inst[24:20]
//  id_rd_addr   out  5     head inst[11:7]
//  buf_count    out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset (rst_n=0, async): wr_ptr=rd_ptr=0, count=0; id_valid=0, if_ready=1, id_pc=0, id_inst=NOP,
//    addrs=0, buf_count=0. Storage array is not reset; outputs are masked while empty.
//  - push = if_valid & if_ready & ~flush;  pop = id_valid & id_ready.
//  - if_ready = (count != DEPTH); registered-state only, no combinational path from id_ready.
//  - id_valid = (count != 0) & ~flush.
//  - Latency: entry pushed at edge N is visible on id_* after edge N (one cycle). No bypass from if_* to id_*.
//  - Push writes mem[wr_ptr] and increments wr_ptr mod DEPTH. Pop increments rd_ptr mod DEPTH.
//  - count' = count + push - pop. Simultaneous push and pop leaves count unchanged; allowed at any count < DEPTH.
//  - Full (count == DEPTH): if_ready=0, fetch holds; pop frees one slot; if_ready=1 next cycle.
//  - Empty: id_valid=0; id_pc=0, id_inst=NOP, addrs=0. id_ready is ignored.
//  - Pointer wrap: DEPTH is a power of two, so pointers are $clog2(DEPTH) bits and wrap naturally.
//  - flush=1: next state count=0, wr_ptr=rd_ptr=0; the push and pop in that cycle are suppressed.
//    Entry accepted the cycle after flush deasserts is the first valid one.
//  - flush has priority over push/pop. rst_n has priority over everything.
//  - Reset asserted mid-transfer drops all entries immediately (async); no partial state survives.
//  - id_* outputs are stable while id_valid=1 and id_ready=0 (decode stall).
// STRUCTURE
//  - Shared defines header: `RegBus, `RegAddrBus, `ZeroWord, NOP encoding, inst field bit positions (RS1/RS2/RD ranges).
//  - One sub-module: if_id_ptr_fifo: generic DEPTH x (2*XLEN) sync FIFO with ptrs/count, flush and
//    async active-low reset.
//  - Top level: fetch handshake gating, empty masking, field slicing.
// TESTING
//  1 Reset: rst_n=0 mid-run with count=2 -> same cycle: id_valid=0, id_inst=32'h00000013, buf_count=0, if_ready=1.
//  2 Single pass: push pc=0x100, inst=0x00208033 (add x0? rd=0,rs1=1,rs2=2) -> next cycle id_valid=1,
//    id_rs1_addr=1, id_rs2_addr=2, id_rd_addr=0, id_pc=0x100.
//  3 Fill/stall: id_ready=0, push 0x100 and 0x104 -> buf_count=2, if_ready=0; third if_valid is not accepted;
//    id_pc stays 0x100 throughout.
//  4 Streaming: if_valid=id_ready=1 for 8 cycles, pcs 0x0..0x1C -> id_pc sequence 0x0..0x1C, one per cycle,
//    buf_count constant at 1.
//  5 Flush: count=2, flush=1 with if_valid=1 (pc=0x200) -> next cycle buf_count=0, id_valid=0;
//    push pc=0x300 after flush -> id_pc=0x300 (0x200 never appears).
//  6 Wrap: 5 push/pop rounds at DEPTH=2 with alternating stalls -> order preserved;
//    scoreboard sees no drop or duplicate.

Source files
------------

// File: rtl/if_id_inst_buffer_pkg.sv
// Shared definitions for the IF/ID instruction buffer: bus widths, NOP encoding
// and RV32I register-field positions.
package if_id_inst_buffer_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;

  localparam logic [REG_BUS-1:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [REG_BUS-1:0] NOP_INST  = 32'h0000_0013;

  localparam int RS1_MSB = 19;
  localparam int RS1_LSB = 15;
  localparam int RS2_MSB = 24;
  localparam int RS2_LSB = 20;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 7;

  function automatic logic [REG_ADDR_BUS-1:0] rs1_of(input logic [REG_BUS-1:0] inst);
    return inst[RS1_MSB:RS1_LSB];
  endfunction

  function automatic logic [REG_ADDR_BUS-1:0] rs2_of(input logic [REG_BUS-1:0] inst);
    return inst[RS2_MSB:RS2_LSB];
  endfunction

  function automatic logic [REG_ADDR_BUS-1:0] rd_of(input logic [REG_BUS-1:0] inst);
    return inst[RD_MSB:RD_LSB];
  endfunction

endpackage

// File: rtl/if_id_ptr_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with read/write pointers, occupancy
// count, synchronous flush and asynchronous active-low reset.
module if_id_ptr_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == CNT_W'(0));
  assign push_s = push & ~full & ~flush;
  assign pop_s  = pop & ~empty & ~flush;
  assign rdata  = mem_q[rd_ptr_q];
  assign count  = count_q;

  // Next-state pointers and occupancy; flush clears everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = PTR_W'(0);
      rd_ptr_d = PTR_W'(0);
      count_d  = CNT_W'(0);
    end else begin
      // Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH by themselves.
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; the consumer masks the read data while empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/if_id_inst_buffer.sv
// IF/ID instruction buffer: queues fetched {pc, inst} pairs, presents the head
// to decode with register-address slicing, and drops everything on a flush.
module if_id_inst_buffer
  import if_id_inst_buffer_pkg::*;
#(
  parameter int               DEPTH = 2,
  parameter int               XLEN  = 32,
  parameter logic [XLEN-1:0]  NOP   = NOP_INST
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [XLEN-1:0]          if_pc,
  input  logic [XLEN-1:0]          if_inst,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [XLEN-1:0]          id_pc,
  output logic [XLEN-1:0]          id_inst,
  output logic [4:0]               id_rs1_addr,
  output logic [4:0]               id_rs2_addr,
  output logic [4:0]               id_rd_addr,
  output logic [$clog2(DEPTH):0]   buf_count
);

  logic                   push_s;
  logic                   pop_s;
  logic                   full_s;
  logic                   empty_s;
  logic [2*XLEN-1:0]      rdata_s;
  logic [$clog2(DEPTH):0] count_s;

  // if_ready depends only on registered occupancy, never on id_ready.
  assign if_ready  = ~full_s;
  assign id_valid  = ~empty_s & ~flush;
  assign push_s    = if_valid & ~full_s & ~flush;
  assign pop_s     = id_valid & id_ready;
  assign buf_count = count_s;

  if_id_ptr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({if_pc, if_inst}),
    .rdata (rdata_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Head presentation: unwritten storage is hidden behind a NOP while empty.
  always_comb begin
    id_pc   = ZERO_WORD;
    id_inst = NOP;
    if (empty_s) begin
      id_pc   = ZERO_WORD;
      id_inst = NOP;
    end else begin
      id_pc   = rdata_s[2*XLEN-1:XLEN];
      id_inst = rdata_s[XLEN-1:0];
    end
  end

  // Register-file read addresses; forced to x0 while empty.
  always_comb begin
    id_rs1_addr = 5'd0;
    id_rs2_addr = 5'd0;
    id_rd_addr  = 5'd0;
    if (empty_s) begin
      id_rs1_addr = 5'd0;
      id_rs2_addr = 5'd0;
      id_rd_addr  = 5'd0;
    end else begin
      id_rs1_addr = rs1_of(id_inst);
      id_rs2_addr = rs2_of(id_inst);
      id_rd_addr  = rd_of(id_inst);
    end
  end

endmodule

// File: tb/tb_if_id_inst_buffer.sv
// Directed, scoreboard-checked bench for the IF/ID instruction buffer.
module tb_if_id_inst_buffer;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [4:0]  id_rd_addr;
  logic [1:0]  buf_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  if_id_inst_buffer #(
    .DEPTH (DEPTH),
    .XLEN  (32),
    .NOP   (NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rd_addr  (id_rd_addr),
    .buf_count   (buf_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, check outputs against the model,
  // then advance the model to the state after the coming posedge.
  task automatic step(input logic fl, input logic iv, input logic [31:0] pc,
                      input logic [31:0] inst, input logic ir);
    ent_t e;
    ent_t h;
    logic exp_valid;
    logic exp_ready;
    @(negedge clk);
    flush    = fl;
    if_valid = iv;
    if_pc    = pc;
    if_inst  = inst;
    id_ready = ir;
    #1;
    exp_valid = (q.size() != 0) && !fl;
    exp_ready = (q.size() != DEPTH);
    chk("id_valid", 32'(id_valid), 32'(exp_valid));
    chk("if_ready", 32'(if_ready), 32'(exp_ready));
    chk("buf_count", 32'(buf_count), 32'(q.size()));
    if (q.size() != 0) begin
      h = q[0];
      chk("head_pc", id_pc, h.pc);
      chk("head_inst", id_inst, h.inst);
      chk("rs1", 32'(id_rs1_addr), 32'(h.inst[19:15]));
      chk("rs2", 32'(id_rs2_addr), 32'(h.inst[24:20]));
      chk("rd", 32'(id_rd_addr), 32'(h.inst[11:7]));
    end else begin
      chk("empty_pc", id_pc, 32'h0);
      chk("empty_inst", id_inst, NOP);
      chk("empty_rs1", 32'(id_rs1_addr), 32'h0);
      chk("empty_rs2", 32'(id_rs2_addr), 32'h0);
      chk("empty_rd", 32'(id_rd_addr), 32'h0);
    end
    if (fl) begin
      q.delete();
    end else begin
      if (exp_valid && ir) begin
        e = q.pop_front();
        chk("pop_pc", id_pc, e.pc);
        chk("pop_inst", id_inst, e.inst);
      end
      if (iv && exp_ready) begin
        e.pc   = pc;
        e.inst = inst;
        q.push_back(e);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    if_valid = 1'b0;
    if_pc    = 32'h0;
    if_inst  = 32'h0;
    id_ready = 1'b0;
    #12;
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_if_ready", 32'(if_ready), 32'h1);
    chk("rst_id_inst", id_inst, NOP);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_buf_count", 32'(buf_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single pass with field slicing
    step(1'b0, 1'b1, 32'h100, 32'h0020_8033, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("t2_valid", 32'(id_valid), 32'h1);
    chk("t2_rs1", 32'(id_rs1_addr), 32'h1);
    chk("t2_rs2", 32'(id_rs2_addr), 32'h2);
    chk("t2_rd", 32'(id_rd_addr), 32'h0);
    chk("t2_pc", id_pc, 32'h100);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Fill and stall: third offer must be refused, head held
    step(1'b0, 1'b1, 32'h100, 32'h0031_00b3, 1'b0);
    step(1'b0, 1'b1, 32'h104, 32'h0052_0233, 1'b0);
    step(1'b0, 1'b1, 32'h108, 32'h0073_03b3, 1'b0);
    chk("t3_if_ready", 32'(if_ready), 32'h0);
    chk("t3_count", 32'(buf_count), 32'h2);
    chk("t3_pc", id_pc, 32'h100);
    step(1'b0, 1'b1, 32'h108, 32'h0073_03b3, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Streaming: one in, one out per cycle
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 32'(i * 4), $urandom(), 1'b1);
    end
    chk("t4_count", 32'(buf_count), 32'h1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Flush with a competing push
    step(1'b0, 1'b1, 32'h400, $urandom(), 1'b0);
    step(1'b0, 1'b1, 32'h404, $urandom(), 1'b0);
    step(1'b1, 1'b1, 32'h200, $urandom(), 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("t5_count", 32'(buf_count), 32'h0);
    chk("t5_valid", 32'(id_valid), 32'h0);
    step(1'b0, 1'b1, 32'h300, $urandom(), 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("t5_pc", id_pc, 32'h300);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Pointer wrap with alternating decode stalls
    for (int r = 0; r < 10; r++) begin
      step(1'b0, 1'b1, 32'h500 + 32'(r * 4), $urandom(), r[0]);
    end
    for (int r = 0; r < 4; r++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    end

    // Asynchronous reset with two entries held
    step(1'b0, 1'b1, 32'h600, $urandom(), 1'b0);
    step(1'b0, 1'b1, 32'h604, $urandom(), 1'b0);
    @(negedge clk);
    if_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("t1_id_valid", 32'(id_valid), 32'h0);
    chk("t1_id_inst", id_inst, NOP);
    chk("t1_buf_count", 32'(buf_count), 32'h0);
    chk("t1_if_ready", 32'(if_ready), 32'h1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h700, $urandom(), 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
